// File: rtl/rate_mult_decoder.sv
// Recovers the rate word of an 8-stage binary rate multiplier by counting
// its Z pulses over one STEPS-long window of qualified P_0 steps.
module rate_mult_decoder #(
    parameter int STEPS = 256,
    parameter int CW    = 9
) (
    input  logic          CK,
    input  logic          RST,
    input  logic          P_0_pad,
    input  logic          Z_pad,
    input  logic          START,
    input  logic          CONT,
    input  logic          RATE_RDY,
    output logic [CW-1:0] RATE,
    output logic          RATE_VLD,
    output logic          BUSY
);

    localparam int SW = $clog2(STEPS);
    localparam logic [CW:0] PULSE_MAX = (CW+1)'(STEPS);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t        state;
    logic [SW-1:0] step_cnt;
    logic [CW-1:0] pulse_cnt;
    logic          step_last;

    // Clamp at STEPS; a full window of pulses is the largest legal count.
    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] cnt, input logic inc);
        logic [CW:0] sum;
        sum = {1'b0, cnt} + {{CW{1'b0}}, inc};
        if (sum > PULSE_MAX) begin
            return PULSE_MAX[CW-1:0];
        end
        return sum[CW-1:0];
    endfunction

    // STEPS is a power of two, so the final step is the all-ones count.
    assign step_last = &step_cnt;

    always_ff @(posedge CK) begin
        if (RST) begin
            state     <= IDLE;
            step_cnt  <= '0;
            pulse_cnt <= '0;
            RATE      <= '0;
            RATE_VLD  <= 1'b0;
            BUSY      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (START) begin
                        step_cnt  <= '0;
                        pulse_cnt <= '0;
                        BUSY      <= 1'b1;
                        state     <= COUNT;
                    end
                end
                COUNT: begin
                    if (P_0_pad) begin
                        step_cnt  <= step_cnt + SW'(1);
                        pulse_cnt <= sat_inc(pulse_cnt, Z_pad);
                        if (step_last) begin
                            RATE     <= sat_inc(pulse_cnt, Z_pad);
                            RATE_VLD <= 1'b1;
                            BUSY     <= 1'b0;
                            state    <= DONE;
                        end
                    end
                end
                DONE: begin
                    if (RATE_RDY) begin
                        RATE_VLD <= 1'b0;
                        if (CONT) begin
                            step_cnt  <= '0;
                            pulse_cnt <= '0;
                            BUSY      <= 1'b1;
                            state     <= COUNT;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: begin
                    RATE_VLD <= 1'b0;
                    BUSY     <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rate_mult_decoder.sv
// Randomized scoreboard bench for rate_mult_decoder: windows are planned up
// front, their expected rate pushed, and a monitor checks each result.
module tb_rate_mult_decoder;

    localparam int STEPS = 256;
    localparam int CW    = 9;

    logic          CK = 1'b0;
    logic          RST;
    logic          P_0_pad;
    logic          Z_pad;
    logic          START;
    logic          CONT;
    logic          RATE_RDY;
    logic [CW-1:0] RATE;
    logic          RATE_VLD;
    logic          BUSY;

    typedef struct {
        int rate;
        int last_edge;
    } exp_t;

    exp_t sbq[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    logic vld_q = 1'b0;
    logic [7:0] rm_c;
    int   rm_phase;

    rate_mult_decoder #(.STEPS(STEPS), .CW(CW)) dut (
        .CK       (CK),
        .RST      (RST),
        .P_0_pad  (P_0_pad),
        .Z_pad    (Z_pad),
        .START    (START),
        .CONT     (CONT),
        .RATE_RDY (RATE_RDY),
        .RATE     (RATE),
        .RATE_VLD (RATE_VLD),
        .BUSY     (BUSY)
    );

    always #5 CK = ~CK;
    always @(posedge CK) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp_v);
        checks++;
        if (act != exp_v) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp_v, cyc);
        end
    endtask

    // Monitor: each new result must match the oldest planned window.
    always @(negedge CK) begin
        if (RATE_VLD && !vld_q) begin
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_result: RATE=%0d with no window pending", RATE);
            end else begin
                mon_e = sbq.pop_front();
                check("rate", int'(RATE), mon_e.rate);
                check("result_edge", cyc, mon_e.last_edge);
                check("busy_in_done", int'(BUSY), 0);
            end
        end
        vld_q <= RATE_VLD;
    end

    task automatic tick();
        @(posedge CK);
        #1;
    endtask

    // Ideal binary rate multiplier: stage i fires when the counter's lowest set bit is bit i-1.
    function automatic logic rm_pulse(input int n);
        for (int i = 1; i <= 8; i++) begin
            if (rm_c[8-i] && (n % (1 << i)) == (1 << (i - 1))) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic logic gen_z(input int mode, input int k);
        case (mode)
            0: return 1'b1;
            1: return (k % 2) == 0;
            2: return 1'b0;
            3: return (k % 4) == 0;
            4: return rm_pulse((rm_phase + k) % 256);
            default: return 1'($urandom_range(0, 1));
        endcase
    endfunction

    task automatic do_start();
        START   = 1'b1;
        P_0_pad = 1'b1;
        Z_pad   = 1'b1;
        tick();
        START = 1'b0;
        check("busy_after_start", int'(BUSY), 1);
    endtask

    // Plans nsteps qualified steps with P_0 at duty percent, pushes the expectation, then drives.
    task automatic run_window(input int mode, input int duty, input int nsteps, input bit record);
        logic pv[$];
        logic zv[$];
        int   k = 0;
        int   zc = 0;
        while (k < nsteps) begin
            logic p;
            logic z;
            p = ($urandom_range(0, 99) < duty);
            if (p) begin
                z = gen_z(mode, k);
                zc += int'(z);
                k++;
            end else begin
                z = 1'($urandom_range(0, 1));
            end
            pv.push_back(p);
            zv.push_back(z);
        end
        if (record) sbq.push_back('{rate: (mode == 4) ? int'(rm_c) : zc, last_edge: cyc + pv.size()});
        for (int i = 0; i < pv.size(); i++) begin
            P_0_pad = pv[i];
            Z_pad   = zv[i];
            tick();
        end
    endtask

    // Cycle after the last step with RATE_RDY high: transfer happens here, steps are ignored.
    task automatic gap(input bit cont_v);
        CONT    = cont_v;
        P_0_pad = 1'b1;
        Z_pad   = 1'b1;
        tick();
        check("vld_after_xfer", int'(RATE_VLD), 0);
        check("busy_after_xfer", int'(BUSY), int'(cont_v));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        logic [CW-1:0] held;
        RST = 1'b1; P_0_pad = 1'b0; Z_pad = 1'b0; START = 1'b0; CONT = 1'b0; RATE_RDY = 1'b1;
        rm_c = 8'b1010_0001;
        rm_phase = int'($urandom_range(0, 255));
        tick();
        tick();
        check("reset_rate", int'(RATE), 0);
        check("reset_vld", int'(RATE_VLD), 0);
        check("reset_busy", int'(BUSY), 0);
        RST = 1'b0;
        tick();

        // Full-rate windows: all ones, alternating, all zeros.
        do_start(); run_window(0, 100, STEPS, 1'b1); gap(1'b0);
        do_start(); run_window(1, 100, STEPS, 1'b1); gap(1'b0);
        do_start(); run_window(2, 100, STEPS, 1'b1); gap(1'b0);

        // Golden multiplier with C = 10100001 and 50% P_0 duty.
        do_start(); run_window(4, 50, STEPS, 1'b1); gap(1'b0);

        // Backpressure with START pulses while DONE.
        RATE_RDY = 1'b0;
        do_start(); run_window(5, 70, STEPS, 1'b1);
        held = RATE;
        for (int i = 0; i < 20; i++) begin
            START   = (i % 5) == 0;
            P_0_pad = 1'b1;
            Z_pad   = 1'($urandom_range(0, 1));
            tick();
            check("bp_vld", int'(RATE_VLD), 1);
            check("bp_rate", int'(RATE), int'(held));
            check("bp_busy", int'(BUSY), 0);
        end
        START = 1'b0;
        RATE_RDY = 1'b1;
        gap(1'b0);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("idle_busy", int'(BUSY), 0);
            check("idle_vld", int'(RATE_VLD), 0);
        end

        // Continuous mode, back-to-back windows of RATE=64.
        do_start();
        for (int w = 0; w < 3; w++) begin
            run_window(3, 80, STEPS, 1'b1);
            gap(w < 2);
        end

        // Reset at step 100 discards the window.
        do_start(); run_window(5, 100, 100, 1'b0);
        RST = 1'b1; P_0_pad = 1'b1;
        tick();
        RST = 1'b0;
        check("midrst_rate", int'(RATE), 0);
        check("midrst_vld", int'(RATE_VLD), 0);
        check("midrst_busy", int'(BUSY), 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("midrst_no_result", int'(RATE_VLD), 0);
        end
        do_start(); run_window(5, 60, STEPS, 1'b1); gap(1'b0);

        tick();
        tick();
        check("scoreboard_empty", sbq.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
